matrix_stream_receiver: RTL and testbench
=========================================

# matrix_stream_receiver

Receive-side counterpart of the matrix output path. Samples the multi-channel SPI byte stream (spi_clk / spi_mosi) and the column shift-register control lines (ser_clk / ser_data / ser_stcp / ser_n_enable) as an asynchronous sink, reassembles per-channel bytes, and tracks column selection and frame boundaries. It is used as on-board loopback checker and as the capture front end for the FPGA-side matrix emulator.

## Interface
- CHANNEL_NUMBER, 3, number of parallel MOSI lanes
- SPI_SIZE, 8, bits per SPI word
- MSB_FIRST, 1, 1: first received bit is data bit SPI_SIZE-1; 0: first bit is bit 0
- COLUMN_COUNT, 16, length of column shift-register chain
- BYTES_PER_COLUMN, 24, words per lane per column
- TIMEOUT_CYCLES, 1024, clk cycles without spi_clk rising edge that abort a partial word
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- spi_clk  in  1  SPI clock from transmitter, asynchronous
- spi_mosi  in  CHANNEL_NUMBER  data lanes, sampled on spi_clk rising edge
- ser_clk, ser_data, ser_stcp, ser_n_enable  in  1 each  column shift-register controls, asynchronous
- data_out  out  CHANNEL_NUMBER*SPI_SIZE  received words, lane i at bits [i*SPI_SIZE +: SPI_SIZE]
- byte_valid  out  1  one-cycle pulse, data_out/byte_index valid
- byte_index  out  $clog2(BYTES_PER_COLUMN)  index of delivered word within column
- column_done  out  1  pulse with byte_valid of word BYTES_PER_COLUMN-1
- column_latch  out  1  pulse on ser_stcp rising edge
- column_index  out  $clog2(COLUMN_COUNT)  index of set bit in latched column vector
- frame_start  out  1  pulse with column_latch when latched vector == 1 (column 0)
- onehot_error  out  1  pulse with column_latch when latched vector not one-hot
- partial_column_error  out  1  pulse with column_latch when word counter != 0
- timeout_error  out  1  pulse when partial word aborted
- output_enabled  out  1  synchronized inverse of ser_n_enable

## Operation
- All five control/clock inputs and every spi_mosi lane pass through identical 2-FF synchronizers plus one history FF; edge event = sync2 & ~history.
- Word FSM: IDLE (bit_cnt 0) -> SHIFT on first spi_clk edge; each edge shifts all lanes (MSB_FIRST=1: shift left, new bit into LSB; 0: shift right, new bit into MSB). On SPI_SIZE-th edge: load data_out, pulse byte_valid, return IDLE.
- Timeout: idle counter clears on every spi_clk edge; in SHIFT, reaching TIMEOUT_CYCLES discards partial word, pulses timeout_error, -> IDLE. No timeout in IDLE.
- Word counter: increments per delivered word; wraps BYTES_PER_COLUMN-1 -> 0 with column_done.
- Column chain: ser_clk edge shifts synchronized ser_data into bit 0, bits move toward bit COLUMN_COUNT-1. ser_stcp edge copies chain to latched vector, pulses column_latch, clears word counter.
- column_index: lowest set bit of latched vector; 0 if vector is zero.
- Simultaneous word completion and stcp edge: word delivered with pre-clear byte_index; partial_column_error evaluated on post-increment count; counter ends at 0.
- Simultaneous ser_clk and ser_stcp edges: latch takes chain value before the shift (74HC595 semantics).

## Timing
- Reset values: data_out 0, all pulses 0, byte_index 0, column_index 0, output_enabled 0, chain and latched vector 0, FSM IDLE, counters 0.
- rst asynchronous: outputs reach reset values without clk; mid-word or mid-column reset discards all partial state.
- Latency: pin rising edge captured at clk edge k -> byte_valid / column_latch high in the cycle after edge k+2.
- Input constraint: spi_clk, ser_clk, ser_stcp high and low phases >= 2 clk periods; data stable from 1 clk before to 1 clk after its clock edge at the pins.
- All pulses exactly one cycle; data_out holds until next word.

## Test plan
- Reset, send lanes 0xA5/0x3C/0xFF MSB-first at spi_clk = clk/8 -> single byte_valid, data_out = 0xFF3CA5, byte_index 0; repeat with MSB_FIRST=0 same bit order -> lane0 0xA5 bit-reversed (0xA5), lane1 0x3C.
- 24 consecutive words of 0x00..0x17 -> byte_index 0..23, column_done only with word 23, 25th word byte_index 0.
- Shift 0x0001 (16 ser_clk), pulse ser_stcp -> column_index 0, frame_start, no onehot_error; shift 0x0003 -> onehot_error, column_index 0; stcp after 5 words -> partial_column_error.
- 5 spi_clk edges, then idle 1024 cycles -> timeout_error exactly once, no byte_valid; next 8 edges deliver correct word.
- rst mid-word (bit 4) -> outputs reset immediately; next full word correct, byte_index 0.
- ser_n_enable low -> output_enabled 1 after 3 clk; high -> 0 after 3 clk.

Source files
------------

// File: rtl/matrix_stream_receiver.sv
// matrix_stream_receiver
//   Asynchronous-sink capture of the matrix output path. Samples a
//   multi-lane SPI byte stream and the column shift-register controls,
//   rebuilds per-lane words and tracks column selection / frame start.
// Ports:
//   clk, rst              system clock, async active-high reset
//   spi_clk, spi_mosi     SPI clock and CHANNEL_NUMBER data lanes (async)
//   ser_clk, ser_data     column chain shift clock / data (async)
//   ser_stcp              column latch strobe (async)
//   ser_n_enable          active-low output enable (async)
//   data_out/byte_valid/byte_index/column_done   word delivery
//   column_latch/column_index/frame_start        column tracking
//   onehot_error/partial_column_error/timeout_error  error pulses
//   output_enabled        synchronized ~ser_n_enable

// 2-FF synchronizer plus history FF; rise_o is a single-cycle edge event.
module msr_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o,
  output logic rise_o
);
  logic s1_q, s2_q, hist_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= RST_VAL;
      s2_q   <= RST_VAL;
      hist_q <= RST_VAL;
    end else begin
      s1_q   <= d_i;
      s2_q   <= s1_q;
      hist_q <= s2_q;
    end
  end

  assign q_o    = s2_q;
  assign rise_o = s2_q & ~hist_q;
endmodule

// Per-lane deserializer. word_nxt_o is the value after the current shift,
// so the top can capture a complete word on the final edge.
module msr_lane #(
  parameter int SPI_SIZE  = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                shift_i,
  input  logic                clear_i,
  input  logic                bit_i,
  output logic [SPI_SIZE-1:0] word_nxt_o
);
  logic [SPI_SIZE-1:0] sh_q;

  if (MSB_FIRST != 0) begin : g_msb
    assign word_nxt_o = {sh_q[SPI_SIZE-2:0], bit_i};
  end else begin : g_lsb
    assign word_nxt_o = {bit_i, sh_q[SPI_SIZE-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          sh_q <= '0;
    else if (clear_i) sh_q <= '0;
    else if (shift_i) sh_q <= word_nxt_o;
  end
endmodule

module matrix_stream_receiver #(
  parameter int CHANNEL_NUMBER   = 3,
  parameter int SPI_SIZE         = 8,
  parameter int MSB_FIRST        = 1,
  parameter int COLUMN_COUNT     = 16,
  parameter int BYTES_PER_COLUMN = 24,
  parameter int TIMEOUT_CYCLES   = 1024
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 spi_clk,
  input  logic [CHANNEL_NUMBER-1:0]            spi_mosi,
  input  logic                                 ser_clk,
  input  logic                                 ser_data,
  input  logic                                 ser_stcp,
  input  logic                                 ser_n_enable,
  output logic [CHANNEL_NUMBER*SPI_SIZE-1:0]   data_out,
  output logic                                 byte_valid,
  output logic [$clog2(BYTES_PER_COLUMN)-1:0]  byte_index,
  output logic                                 column_done,
  output logic                                 column_latch,
  output logic [$clog2(COLUMN_COUNT)-1:0]      column_index,
  output logic                                 frame_start,
  output logic                                 onehot_error,
  output logic                                 partial_column_error,
  output logic                                 timeout_error,
  output logic                                 output_enabled
);
  localparam int CH = CHANNEL_NUMBER;
  localparam int S  = SPI_SIZE;
  localparam int C  = COLUMN_COUNT;
  localparam int IW = $clog2(BYTES_PER_COLUMN);
  localparam int CW = $clog2(COLUMN_COUNT);
  localparam int BW = $clog2(SPI_SIZE);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic {IDLE, SHIFT} state_t;

  typedef struct packed {
    logic          latch;
    logic          frame;
    logic          onehot_err;
    logic          partial_err;
  } col_evt_t;

  // ---------------- synchronizers ----------------
  logic          spi_rise, ser_clk_rise, stcp_rise, ser_data_s, n_en_s;
  logic [CH-1:0] mosi_s;
  logic [CH-1:0] unused_mosi_rise;
  logic [4:0]    unused_misc;

  msr_sync u_spi  (.clk(clk), .rst(rst), .d_i(spi_clk),  .q_o(unused_misc[0]), .rise_o(spi_rise));
  msr_sync u_sclk (.clk(clk), .rst(rst), .d_i(ser_clk),  .q_o(unused_misc[1]), .rise_o(ser_clk_rise));
  msr_sync u_stcp (.clk(clk), .rst(rst), .d_i(ser_stcp), .q_o(unused_misc[2]), .rise_o(stcp_rise));
  msr_sync u_sdat (.clk(clk), .rst(rst), .d_i(ser_data), .q_o(ser_data_s),     .rise_o(unused_misc[3]));
  // Enable resets to its inactive level so output_enabled stays low out of reset.
  msr_sync #(.RST_VAL(1'b1)) u_nen
                  (.clk(clk), .rst(rst), .d_i(ser_n_enable), .q_o(n_en_s),     .rise_o(unused_misc[4]));

  // ---------------- lanes ----------------
  logic [CH-1:0][S-1:0] lane_nxt;
  logic                 abort, word_done;

  for (genvar g = 0; g < CH; g++) begin : g_lane
    msr_sync u_sync (.clk(clk), .rst(rst), .d_i(spi_mosi[g]), .q_o(mosi_s[g]),
                     .rise_o(unused_mosi_rise[g]));
    msr_lane #(.SPI_SIZE(S), .MSB_FIRST(MSB_FIRST)) u_lane (
      .clk(clk), .rst(rst), .shift_i(spi_rise), .clear_i(abort),
      .bit_i(mosi_s[g]), .word_nxt_o(lane_nxt[g]));
  end

  // ---------------- word FSM ----------------
  state_t              state_q;
  logic [BW-1:0]       bit_cnt_q;
  logic [TW-1:0]       idle_q;
  logic [CH*S-1:0]     data_q;
  logic                byte_valid_q, column_done_q, timeout_q;
  logic [IW-1:0]       byte_index_q, word_cnt_q, word_inc;

  assign word_done = spi_rise && (bit_cnt_q == BW'(S-1));
  assign abort     = (state_q == SHIFT) && !spi_rise && (idle_q == TW'(TIMEOUT_CYCLES-1));
  assign word_inc  = (word_cnt_q == IW'(BYTES_PER_COLUMN-1)) ? '0 : word_cnt_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      idle_q        <= '0;
      data_q        <= '0;
      byte_valid_q  <= 1'b0;
      byte_index_q  <= '0;
      column_done_q <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      byte_valid_q  <= word_done;
      column_done_q <= word_done && (word_cnt_q == IW'(BYTES_PER_COLUMN-1));
      timeout_q     <= abort;
      if (word_done) begin
        data_q       <= lane_nxt;
        byte_index_q <= word_cnt_q;
      end
      case (state_q)
        IDLE: begin
          idle_q <= '0;
          if (spi_rise) begin
            bit_cnt_q <= word_done ? '0 : BW'(1);
            state_q   <= word_done ? IDLE : SHIFT;
          end
        end
        SHIFT: begin
          if (spi_rise) begin
            idle_q <= '0;
            if (word_done) begin
              bit_cnt_q <= '0;
              state_q   <= IDLE;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end else if (abort) begin
            idle_q    <= '0;
            bit_cnt_q <= '0;
            state_q   <= IDLE;
          end else begin
            idle_q <= idle_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // ---------------- column chain / latch ----------------
  logic [C-1:0] chain_q, latch_q;
  col_evt_t     evt_q;
  logic         oen_q;

  function automatic logic [CW-1:0] low_idx(input logic [C-1:0] v);
    low_idx = '0;
    for (int i = C-1; i >= 0; i--)
      if (v[i]) low_idx = CW'(i);
  endfunction

  function automatic logic is_onehot(input logic [C-1:0] v);
    is_onehot = (v != '0) && ((v & (v - C'(1))) == '0);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_cnt_q <= '0;
      chain_q    <= '0;
      latch_q    <= '0;
      evt_q      <= '0;
      oen_q      <= 1'b0;
    end else begin
      // stcp wins the counter; a word finishing on the same cycle still
      // counts toward the partial-column check via word_inc.
      if (stcp_rise)      word_cnt_q <= '0;
      else if (word_done) word_cnt_q <= word_inc;
      if (ser_clk_rise)   chain_q    <= {chain_q[C-2:0], ser_data_s};
      // Nonblocking read of chain_q: latch sees the pre-shift value.
      if (stcp_rise)      latch_q    <= chain_q;
      evt_q.latch       <= stcp_rise;
      evt_q.frame       <= stcp_rise && (chain_q == C'(1));
      evt_q.onehot_err  <= stcp_rise && !is_onehot(chain_q);
      evt_q.partial_err <= stcp_rise && ((word_done ? word_inc : word_cnt_q) != '0);
      oen_q             <= ~n_en_s;
    end
  end

  assign data_out             = data_q;
  assign byte_valid           = byte_valid_q;
  assign byte_index           = byte_index_q;
  assign column_done          = column_done_q;
  assign timeout_error        = timeout_q;
  assign column_latch         = evt_q.latch;
  assign frame_start          = evt_q.frame;
  assign onehot_error         = evt_q.onehot_err;
  assign partial_column_error = evt_q.partial_err;
  assign column_index         = low_idx(latch_q);
  assign output_enabled       = oen_q;
endmodule

// File: tb/tb_matrix_stream_receiver.sv
module tb_matrix_stream_receiver;
  localparam int CH = 3;
  localparam int S  = 8;

  logic clk = 1'b0;
  logic rst;
  logic spi_clk, ser_clk, ser_data, ser_stcp, ser_n_enable;
  logic [CH-1:0] spi_mosi;

  logic [23:0] d0, d1;
  logic        bv0, bv1, cd0, cl0, fs0, oh0, pe0, te0, oe0;
  logic [4:0]  bi0, bi1;
  logic [3:0]  ci0;
  logic        unused1_cd, unused1_cl, unused1_fs, unused1_oh, unused1_pe, unused1_te, unused1_oe;
  logic [3:0]  unused1_ci;

  matrix_stream_receiver #(.MSB_FIRST(1)) dut0 (
    .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
    .ser_clk(ser_clk), .ser_data(ser_data), .ser_stcp(ser_stcp), .ser_n_enable(ser_n_enable),
    .data_out(d0), .byte_valid(bv0), .byte_index(bi0), .column_done(cd0),
    .column_latch(cl0), .column_index(ci0), .frame_start(fs0), .onehot_error(oh0),
    .partial_column_error(pe0), .timeout_error(te0), .output_enabled(oe0));

  matrix_stream_receiver #(.MSB_FIRST(0)) dut1 (
    .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
    .ser_clk(ser_clk), .ser_data(ser_data), .ser_stcp(ser_stcp), .ser_n_enable(ser_n_enable),
    .data_out(d1), .byte_valid(bv1), .byte_index(bi1), .column_done(unused1_cd),
    .column_latch(unused1_cl), .column_index(unused1_ci), .frame_start(unused1_fs),
    .onehot_error(unused1_oh), .partial_column_error(unused1_pe), .timeout_error(unused1_te),
    .output_enabled(unused1_oe));

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int cyc = 0, last_rise = 0;
  int model_wcnt = 0;
  int bv_cnt = 0, to_cnt = 0, latch_cnt = 0;
  int l_idx; bit l_fs, l_oh, l_pe;

  typedef struct packed {
    logic [23:0] d0;
    logic [23:0] d1;
    logic [4:0]  idx;
    logic        done;
  } exp_t;
  exp_t sb[$];
  exp_t e_m;

  typedef struct packed {
    logic [7:0]  l0, l1, l2;
    logic [23:0] e0, e1;
  } vec_t;
  vec_t vt [4];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] x);
    for (int i = 0; i < 8; i++) rev8[i] = x[7-i];
  endfunction

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (bv0 || bv1) chk("bv_lanes_agree", {31'd0, bv1}, {31'd0, bv0});
    if (cd0 && !bv0) begin
      tests++; fails++;
      $display("FAIL done_without_valid: column_done=1 byte_valid=0");
    end
    if ((fs0 || oh0 || pe0) && !cl0) begin
      tests++; fails++;
      $display("FAIL col_flag_without_latch: fs=%0b oh=%0b pe=%0b", fs0, oh0, pe0);
    end
    if (bv0) begin
      bv_cnt++;
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_word: data=%0h idx=%0d", d0, bi0);
      end else begin
        e_m = sb.pop_front();
        chk("data_msb_first", d0, e_m.d0);
        chk("data_lsb_first", d1, e_m.d1);
        chk("byte_index", bi0, e_m.idx);
        chk("byte_index_lsb", bi1, e_m.idx);
        chk("column_done", cd0, e_m.done);
        chk("latency", cyc - last_rise, 3);
      end
    end
    if (te0) to_cnt++;
    if (cl0) begin
      latch_cnt++;
      l_idx = ci0; l_fs = fs0; l_oh = oh0; l_pe = pe0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic reset_all();
    rst = 1'b1;
    spi_clk = 0; ser_clk = 0; ser_stcp = 0; ser_data = 0; ser_n_enable = 1; spi_mosi = '0;
    tick(3);
    rst = 1'b0;
    model_wcnt = 0;
    tick(3);
  endtask

  // Sends the first n bits (MSB first) of each lane at spi_clk = clk/8.
  task automatic send_bits(input logic [7:0] l0, l1, l2, input int n, input bit stcp_last);
    for (int b = 7; b > 7 - n; b--) begin
      spi_mosi = {l2[b], l1[b], l0[b]};
      tick(4);
      spi_clk = 1'b1;
      if (stcp_last && b == 8 - n) ser_stcp = 1'b1;
      last_rise = cyc;
      tick(4);
      spi_clk = 1'b0;
      ser_stcp = 1'b0;
    end
  endtask

  task automatic push(input logic [23:0] e0, e1);
    exp_t x;
    x.d0 = e0; x.d1 = e1;
    x.idx = model_wcnt[4:0];
    x.done = (model_wcnt == 23);
    sb.push_back(x);
    model_wcnt = (model_wcnt == 23) ? 0 : model_wcnt + 1;
  endtask

  task automatic send_model(input logic [7:0] l0, l1, l2);
    push({l2, l1, l0}, {rev8(l2), rev8(l1), rev8(l0)});
    send_bits(l0, l1, l2, 8, 1'b0);
  endtask

  task automatic shift_col(input logic [15:0] v);
    for (int i = 15; i >= 0; i--) begin
      ser_data = v[i];
      tick(3);
      ser_clk = 1'b1;
      tick(3);
      ser_clk = 1'b0;
    end
  endtask

  task automatic stcp_pulse();
    tick(3);
    ser_stcp = 1'b1;
    tick(3);
    ser_stcp = 1'b0;
    tick(3);
    model_wcnt = 0;
  endtask

  task automatic col_check(input string nm, input int c0, input int idx, input bit fs, oh, pe);
    chk({nm, "_latch_cnt"}, latch_cnt - c0, 1);
    chk({nm, "_col_index"}, l_idx, idx);
    chk({nm, "_frame_start"}, {31'd0, l_fs}, {31'd0, fs});
    chk({nm, "_onehot_err"}, {31'd0, l_oh}, {31'd0, oh});
    chk({nm, "_partial_err"}, {31'd0, l_pe}, {31'd0, pe});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, t0, b0;
    vt[0] = '{8'hA5, 8'h3C, 8'hFF, 24'hFF3CA5, 24'hFF3CA5};
    vt[1] = '{8'h01, 8'h80, 8'h0F, 24'h0F8001, 24'hF00180};
    vt[2] = '{8'h12, 8'h34, 8'h56, 24'h563412, 24'h6A2C48};
    vt[3] = '{8'hC3, 8'h00, 8'h5A, 24'h5A00C3, 24'h5A00C3};

    rst = 1'b1;
    spi_clk = 0; ser_clk = 0; ser_stcp = 0; ser_data = 0; ser_n_enable = 1; spi_mosi = '0;
    #1;
    chk("rst_data_out", d0, 0);
    chk("rst_byte_valid", bv0, 0);
    chk("rst_byte_index", bi0, 0);
    chk("rst_column_index", ci0, 0);
    chk("rst_output_enabled", oe0, 0);
    chk("rst_pulses", {cd0, cl0, fs0, oh0, pe0, te0}, 0);
    tick(3);
    rst = 1'b0;
    tick(3);

    // Table-driven words, both bit orders.
    for (int i = 0; i < 4; i++) begin
      push(vt[i].e0, vt[i].e1);
      send_bits(vt[i].l0, vt[i].l1, vt[i].l2, 8, 1'b0);
    end
    tick(8);
    chk("table_drained", sb.size(), 0);

    // Full column of 24 words plus wrap.
    reset_all();
    for (int k = 0; k < 25; k++)
      send_model(8'(k), 8'(k + 8'h40), ~8'(k));
    tick(8);
    chk("column_words", bv_cnt, 29);

    // Column tracking.
    reset_all();
    c0 = latch_cnt; stcp_pulse();            col_check("zero_vec", c0, 0, 0, 1, 0);
    c0 = latch_cnt; shift_col(16'h0001); stcp_pulse(); col_check("col0", c0, 0, 1, 0, 0);
    c0 = latch_cnt; shift_col(16'h0003); stcp_pulse(); col_check("two_hot", c0, 0, 0, 1, 0);
    c0 = latch_cnt; shift_col(16'h0100); stcp_pulse(); col_check("col8", c0, 8, 0, 0, 0);
    for (int k = 0; k < 5; k++) send_model(8'h11, 8'h22, 8'(k));
    c0 = latch_cnt; stcp_pulse();            col_check("partial5", c0, 8, 0, 0, 1);
    send_model(8'h77, 8'h88, 8'h99);
    // Simultaneous ser_clk and ser_stcp: pre-shift value latched.
    shift_col(16'h0004);
    ser_data = 1'b0;
    tick(3);
    c0 = latch_cnt;
    ser_clk = 1'b1; ser_stcp = 1'b1;
    tick(3);
    ser_clk = 1'b0; ser_stcp = 1'b0;
    tick(3);
    col_check("sim_shift_latch", c0, 2, 0, 0, 1);
    model_wcnt = 0;
    c0 = latch_cnt; stcp_pulse();            col_check("after_sim", c0, 3, 0, 0, 0);

    // Word completion coincident with stcp.
    reset_all();
    send_model(8'h01, 8'h02, 8'h03);
    send_model(8'h04, 8'h05, 8'h06);
    push({8'hE7, 8'hD6, 8'hC5}, {rev8(8'hE7), rev8(8'hD6), rev8(8'hC5)});
    c0 = latch_cnt;
    send_bits(8'hC5, 8'hD6, 8'hE7, 8, 1'b1);
    model_wcnt = 0;
    tick(4);
    col_check("word_and_stcp", c0, 0, 0, 1, 1);
    send_model(8'h5A, 8'hA5, 8'h0F);
    tick(8);

    // Timeout on a partial word.
    reset_all();
    t0 = to_cnt; b0 = bv_cnt;
    send_bits(8'hFF, 8'hFF, 8'hFF, 5, 1'b0);
    tick(1000);
    chk("no_early_timeout", to_cnt - t0, 0);
    tick(100);
    chk("timeout_once", to_cnt - t0, 1);
    chk("no_word_on_timeout", bv_cnt - b0, 0);
    send_model(8'h3C, 8'hC3, 8'h81);
    tick(8);

    // Async reset mid-word.
    ser_n_enable = 1'b0;
    tick(6);
    chk("oe_before_rst", oe0, 1);
    chk("data_before_rst", d0, 24'h81C33C);
    send_bits(8'hAA, 8'hBB, 8'hCC, 4, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_data", d0, 0);
    chk("async_rst_oe", oe0, 0);
    chk("async_rst_index", bi0, 0);
    tick(2);
    rst = 1'b0; ser_n_enable = 1'b1; model_wcnt = 0;
    tick(3);
    send_model(8'h96, 8'h69, 8'hF0);
    tick(8);

    // Output enable synchronizer latency.
    ser_n_enable = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("oe_rise_2clk", oe0, 0);
    @(posedge clk); @(negedge clk);
    chk("oe_rise_3clk", oe0, 1);
    #1;
    ser_n_enable = 1'b1;
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("oe_fall_2clk", oe0, 1);
    @(posedge clk); @(negedge clk);
    chk("oe_fall_3clk", oe0, 0);

    tick(20);
    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
